// File: rtl/pool_engine.sv
// pool_engine: 2x2 stride-2 max/avg pooling, DRAM in, DRAM out.
// Define POOL_AVG_EN to add average pooling (mode bit0).
module pool_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 8,
  parameter int PARAM_BASE = 0,
  parameter int OFMAP_BASE = 65536,
  parameter int IFMAP_BASE = 131072
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_wr,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE, LD_PARAM, POOL, DRAIN, DONE
  } state_t;

  state_t                state;
  logic [1:0]            pcnt;
  logic [1:0]            sub;
  logic [DIM_WIDTH-1:0]  w, h, d;
  logic [DIM_WIDTH-1:0]  bx, by, z;
  logic                  sgn;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] ocnt;
  logic [DATA_WIDTH-1:0] p0, p1, p2;

  logic [ADDR_WIDTH-1:0] w_a, row_step, pix_addr;
  logic [DIM_WIDTH:0]    bx3, by3;
  logic                  last_col, last_row, last_plane;
  logic                  degen;
  logic [DATA_WIDTH-1:0] m01, m23, mx, res;

  assign w_a      = ADDR_WIDTH'(w);
  assign row_step = w_a + w_a;
  assign bx3      = {1'b0, bx} + (DIM_WIDTH+1)'(3);
  assign by3      = {1'b0, by} + (DIM_WIDTH+1)'(3);
  assign last_col   = bx3 >= {1'b0, w};
  assign last_row   = by3 >= {1'b0, h};
  assign last_plane = z == d - DIM_WIDTH'(1);
  assign degen = (w < DIM_WIDTH'(2)) ||
                 (h < DIM_WIDTH'(2)) ||
                 (d == '0);

  // sub bit0 steps the column, bit1 steps one row down
  assign pix_addr = row_base + ADDR_WIDTH'(bx) +
                    ADDR_WIDTH'(sub[0]) +
                    (sub[1] ? w_a : '0);

  always_comb begin
    addr_in    = '0;
    dram_en_rd = 1'b0;
    if (state == LD_PARAM) begin
      addr_in    = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(pcnt);
      dram_en_rd = 1'b1;
    end else if (state == POOL) begin
      addr_in    = pix_addr;
      dram_en_rd = 1'b1;
    end
  end

  function automatic logic gt(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  s
  );
    return s ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  assign m01 = gt(p1, p0, sgn) ? p1 : p0;
  assign m23 = gt(data_in, p2, sgn) ? data_in : p2;
  assign mx  = gt(m23, m01, sgn) ? m23 : m01;

`ifdef POOL_AVG_EN
  logic                  avg;
  logic [DATA_WIDTH+1:0] sum;

  function automatic logic [DATA_WIDTH+1:0] ext(
    input logic [DATA_WIDTH-1:0] a,
    input logic                  s
  );
    return {{2{s & a[DATA_WIDTH-1]}}, a};
  endfunction

  assign sum = ext(p0, sgn) + ext(p1, sgn) +
               ext(p2, sgn) + ext(data_in, sgn);
  // low bits of sum>>2 are the same for arithmetic and logical shift
  assign res = avg ? sum[DATA_WIDTH+1:2] : mx;
`else
  assign res = mx;
`endif

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state      <= IDLE;
      pcnt       <= '0;
      sub        <= '0;
      w          <= '0;
      h          <= '0;
      d          <= '0;
      bx         <= '0;
      by         <= '0;
      z          <= '0;
      sgn        <= 1'b0;
      row_base   <= '0;
      ocnt       <= '0;
      p0         <= '0;
      p1         <= '0;
      p2         <= '0;
      data_out   <= '0;
      addr_out   <= '0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
`ifdef POOL_AVG_EN
      avg        <= 1'b0;
`endif
    end else begin
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            state <= LD_PARAM;
            pcnt  <= '0;
          end
        end
        LD_PARAM: begin
          if (dram_valid) begin
            pcnt <= pcnt + 2'd1;
            unique case (pcnt)
              2'd0: w <= data_in[DIM_WIDTH-1:0];
              2'd1: h <= data_in[DIM_WIDTH-1:0];
              2'd2: d <= data_in[DIM_WIDTH-1:0];
              default: begin
                sgn      <= data_in[1];
`ifdef POOL_AVG_EN
                avg      <= data_in[0];
`endif
                sub      <= '0;
                bx       <= '0;
                by       <= '0;
                z        <= '0;
                ocnt     <= '0;
                row_base <= ADDR_WIDTH'(IFMAP_BASE);
                if (degen) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= POOL;
                end
              end
            endcase
          end
        end
        POOL: begin
          if (dram_valid) begin
            sub <= sub + 2'd1;
            unique case (sub)
              2'd0: p0 <= data_in;
              2'd1: p1 <= data_in;
              2'd2: p2 <= data_in;
              default: begin
                data_out   <= res;
                addr_out   <= ADDR_WIDTH'(OFMAP_BASE) + ocnt;
                dram_en_wr <= 1'b1;
                ocnt       <= ocnt + ADDR_WIDTH'(1);
                if (!last_col) begin
                  bx <= bx + DIM_WIDTH'(2);
                end else begin
                  bx <= '0;
                  if (!last_row) begin
                    by       <= by + DIM_WIDTH'(2);
                    row_base <= row_base + row_step;
                  end else begin
                    // skip the unread odd row to reach the next plane
                    by       <= '0;
                    z        <= z + DIM_WIDTH'(1);
                    row_base <= row_base + row_step +
                                (h[0] ? w_a : '0);
                    if (last_plane) state <= DRAIN;
                  end
                end
              end
            endcase
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// tb_pool_engine: directed checks of pool_engine against a tiny DRAM
// model; expected results are hand-computed constants.
module tb_pool_engine;

  logic        clk;
  logic        srstn;
  logic        enable;
  logic        dram_valid;
  logic [31:0] data_in;
  logic [17:0] addr_in;
  logic        dram_en_rd;
  logic [31:0] data_out;
  logic [17:0] addr_out;
  logic        dram_en_wr;
  logic        done;

  pool_engine dut (
    .clk        (clk),
    .srstn      (srstn),
    .enable     (enable),
    .dram_valid (dram_valid),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .dram_en_rd (dram_en_rd),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .dram_en_wr (dram_en_wr),
    .done       (done)
  );

  logic [31:0] prm [4];
  logic [31:0] ifm [64];
  logic [31:0] wq [$];
  logic [17:0] aq [$];
  int          erd [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone, donecyc, lastwr, nextra, bad;
  int cw, ch;
  int off, px, py;
  bit rnd_valid = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    data_in = '0;
    if (addr_in[17]) data_in = ifm[addr_in[5:0]];
    else             data_in = prm[addr_in[1:0]];
  end

  initial begin
    dram_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dram_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dram_en_wr) begin
      wq.push_back(data_out);
      aq.push_back(addr_out);
      lastwr = cyc;
    end
    if (done) begin
      ndone++;
      donecyc = cyc;
    end
    if (dram_en_rd && addr_in[17]) begin
      off = int'(addr_in[16:0]);
      if (cw > 0 && ch > 0) begin
        px = off % cw;
        py = (off % (cw * ch)) / cw;
        if (px >= (cw / 2) * 2 || py >= (ch / 2) * 2) bad++;
      end
      if (dram_valid) begin
        if (erd.size() > 0) check("rd_addr", addr_in, erd.pop_front());
        else nextra++;
      end
    end
  end

  task automatic start(input int w, input int h, input int d,
                       input int m, input bit rnd);
    prm[0] = 32'(w);
    prm[1] = 32'(h);
    prm[2] = 32'(d);
    prm[3] = 32'(m);
    cw = w;
    ch = h;
    wq.delete();
    aq.delete();
    erd.delete();
    ndone = 0;
    nextra = 0;
    bad = 0;
    for (int zz = 0; zz < d; zz++)
      for (int yy = 0; yy + 1 < h; yy += 2)
        for (int xx = 0; xx + 1 < w; xx += 2) begin
          int b;
          b = 131072 + zz * w * h + yy * w + xx;
          erd.push_back(b);
          erd.push_back(b + 1);
          erd.push_back(b + w);
          erd.push_back(b + w + 1);
        end
    rnd_valid = rnd;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (ndone == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", ndone, 1);
    repeat (5) @(negedge clk);
    check("done_once", ndone, 1);
    check("rd_left", erd.size(), 0);
    check("rd_extra", nextra, 0);
  endtask

  task automatic check_writes(input logic [31:0] e [4], input int n);
    check("wr_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      check("wr_data", wq[i], e[i]);
      check("wr_addr", aq[i], 65536 + i);
    end
    if (n > 0) check("done_gap", donecyc - lastwr, 1);
  endtask

  task automatic one_win(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e,
                         input int m, input logic [31:0] exp);
    logic [31:0] ev [4];
    ifm[0] = a;
    ifm[1] = b;
    ifm[2] = c;
    ifm[3] = e;
    start(2, 2, 1, m, 0);
    wait_done();
    ev = '{exp, 0, 0, 0};
    check_writes(ev, 1);
  endtask

  task automatic ramp();
    for (int i = 0; i < 64; i++) ifm[i] = 32'(i);
  endtask

  initial begin
    logic [31:0] ev [4];
    int n;
    srstn = 1'b0;
    enable = 1'b0;
    cw = 0;
    ch = 0;
    for (int i = 0; i < 4; i++) prm[i] = '0;
    ramp();
    repeat (3) @(negedge clk);
    check("rst_addr_in", addr_in, 0);
    check("rst_en_rd", dram_en_rd, 0);
    check("rst_data_out", data_out, 0);
    check("rst_addr_out", addr_out, 0);
    check("rst_en_wr", dram_en_wr, 0);
    check("rst_done", done, 0);
    srstn = 1'b1;
    @(negedge clk);

    start(4, 4, 1, 0, 0);
    wait_done();
    ev = '{5, 7, 13, 15};
    check_writes(ev, 4);

    start(5, 3, 2, 0, 0);
    wait_done();
    ev = '{6, 8, 21, 23};
    check_writes(ev, 4);
    check("odd_edge_reads", bad, 0);

    one_win(32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE,
            2, 32'hFFFFFFFF);
    one_win(32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE,
            0, 32'hFFFFFFFF);
    one_win(32'h1, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFD,
            2, 32'h1);
    one_win(32'h1, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFD,
            0, 32'hFFFFFFFF);
    one_win(32'h3, 32'h1, 32'h2, 32'h9, 0, 32'h9);
    one_win(32'hFFFFFFF0, 32'hFFFFFFF1, 32'hFFFFFFF2, 32'h4,
            2, 32'h4);
`ifdef POOL_AVG_EN
    one_win(32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h0, 3, 32'hFFFFFFFF);
    one_win(32'h1, 32'h2, 32'h3, 32'h5, 1, 32'h2);
    one_win(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            1, 32'hFFFFFFFF);
`else
    one_win(32'h1, 32'h2, 32'h3, 32'h5, 1, 32'h5);
`endif

    ramp();
    start(4, 4, 1, 0, 1);
    wait_done();
    ev = '{5, 7, 13, 15};
    check_writes(ev, 4);
    rnd_valid = 0;

    start(4, 4, 1, 0, 0);
    n = 0;
    while (wq.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_pre", wq.size(), 2);
    srstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_en_rd", dram_en_rd, 0);
    check("abort_en_wr", dram_en_wr, 0);
    check("abort_data", data_out, 0);
    srstn = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_nowr", wq.size(), 2);
    check("abort_nodone", ndone, 0);

    start(4, 4, 1, 0, 0);
    wait_done();
    ev = '{5, 7, 13, 15};
    check_writes(ev, 4);

    ev = '{0, 0, 0, 0};
    start(1, 4, 1, 0, 0);
    wait_done();
    check_writes(ev, 0);
    start(4, 1, 1, 0, 0);
    wait_done();
    check_writes(ev, 0);
    start(4, 4, 0, 0, 0);
    wait_done();
    check_writes(ev, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
